// File: rtl/med_sched_pkg.sv
// Shared types and constants for the multi-channel medicine-dose scheduler.
package med_sched_pkg;

    localparam int DAY_UNITS_DEF = 24;
    // Field widths of chan_t; the scheduler's ID_W / CNT_W default to these and must match them.
    localparam int MED_ID_W  = 4;
    localparam int MED_CNT_W = 5;

    localparam logic [3:0] LED_ALARM = 4'b1111;
    localparam logic [3:0] LED_OFF   = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic                 active;
        logic [MED_ID_W-1:0]  med_id;
        logic [MED_CNT_W-1:0] period;
        logic [MED_CNT_W-1:0] count;
        logic                 pending;
    } chan_t;

endpackage

// File: rtl/med_period_div.sv
// Sequential restoring divider: quotient = DAY_UNITS / freq, one quotient bit per cycle.
// done is high during the final iteration; quotient is valid from the following cycle.
module med_period_div #(
    parameter int CNT_W     = 5,
    parameter int FREQ_W    = 4,
    parameter int DAY_UNITS = 24
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [FREQ_W-1:0] freq,
    output logic              done,
    output logic [CNT_W-1:0]  quotient
);
    localparam int IT_W = $clog2(CNT_W + 1);

    logic [IT_W-1:0]   iter;
    logic [FREQ_W-1:0] dvs;
    logic [FREQ_W-1:0] rem;
    logic [CNT_W-1:0]  shreg;
    logic [FREQ_W:0]   rem_sh;
    logic [FREQ_W-1:0] diff;
    logic              q_bit;

    // shreg starts as the dividend and fills with quotient bits from the right.
    assign rem_sh = {rem, shreg[CNT_W-1]};
    assign q_bit  = (rem_sh >= {1'b0, dvs});
    assign diff   = rem_sh[FREQ_W-1:0] - dvs;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            iter  <= '0;
            dvs   <= '0;
            rem   <= '0;
            shreg <= '0;
        end else if (start) begin
            iter  <= IT_W'(CNT_W);
            dvs   <= freq;
            rem   <= '0;
            shreg <= CNT_W'(DAY_UNITS);
        end else if (iter != '0) begin
            rem   <= q_bit ? diff : rem_sh[FREQ_W-1:0];
            shreg <= {shreg[CNT_W-2:0], q_bit};
            iter  <= iter - IT_W'(1);
        end
    end

    assign done     = (iter == IT_W'(1));
    assign quotient = shreg;

endmodule

// File: rtl/med_sched_multi_ch.sv
// N_CH-channel dose scheduler with round-robin alarm presentation.
// Optional macro MSCH_MISSED_CNT_EN adds per-channel saturating missed-dose counters.
//
// state | meaning
// IDLE  | Cfg_Ready high; accept config, disable immediately when freq=0
// DIV   | divider computing DAY_UNITS/freq
// LOAD  | write period/count into the target channel
module med_sched_multi_ch
    import med_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ID_W      = MED_ID_W,
    parameter int FREQ_W    = 4,
    parameter int CNT_W     = MED_CNT_W,
    parameter int DAY_UNITS = DAY_UNITS_DEF,
    parameter int MISS_W    = 3
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Cfg_Valid,
    output logic                    Cfg_Ready,
    input  logic [$clog2(N_CH)-1:0] Cfg_Ch,
    input  logic [ID_W-1:0]         Cfg_MedID,
    input  logic [FREQ_W-1:0]       Cfg_Freq,
    input  logic                    Tick,
    output logic                    Alarm_Valid,
    output logic [$clog2(N_CH)-1:0] Alarm_Ch,
    output logic [ID_W-1:0]         Alarm_MedID,
    input  logic                    Alarm_Ack,
    output logic [3:0]              LED_Out,
    input  logic [$clog2(N_CH)-1:0] Disp_Ch,
    output logic [CNT_W-1:0]        Disp_Rem,
    output logic [MISS_W-1:0]       Miss_Cnt
);
    localparam int CH_W = $clog2(N_CH);

    cfg_state_e      state, state_nxt;
    logic [CH_W-1:0] cfg_ch_q;
    logic [ID_W-1:0] cfg_id_q;
    logic            div_start, div_done;
    logic [CNT_W-1:0] div_q, period_ld;
    chan_t           chans [N_CH];
    logic [N_CH-1:0] load_v, dis_v, expire_v, ack_v, req;
    logic [CH_W-1:0] last_served, pick_ch, idx;
    logic            pick_any;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Cfg_Ready = 1'b0;
        div_start = 1'b0;
        unique case (state)
            IDLE: begin
                Cfg_Ready = 1'b1;
                if (Cfg_Valid && Cfg_Freq != '0) begin
                    div_start = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV:     if (div_done) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cfg_ch_q <= '0;
            cfg_id_q <= '0;
        end else if (Cfg_Ready && Cfg_Valid) begin
            cfg_ch_q <= Cfg_Ch;
            cfg_id_q <= Cfg_MedID;
        end
    end

    med_period_div #(.CNT_W(CNT_W), .FREQ_W(FREQ_W), .DAY_UNITS(DAY_UNITS)) u_div (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (div_start),
        .freq     (Cfg_Freq),
        .done     (div_done),
        .quotient (div_q)
    );

    // freq above DAY_UNITS gives quotient 0; clamp so the channel still fires every tick.
    assign period_ld = (div_q == '0) ? CNT_W'(1) : div_q;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            load_v[c]   = (state == LOAD) && (cfg_ch_q == CH_W'(c));
            dis_v[c]    = Cfg_Ready && Cfg_Valid && (Cfg_Freq == '0) && (Cfg_Ch == CH_W'(c));
            expire_v[c] = Tick && chans[c].active && (chans[c].count == CNT_W'(1));
            ack_v[c]    = Alarm_Valid && Alarm_Ack && (Alarm_Ch == CH_W'(c));
            req[c]      = chans[c].pending && !load_v[c] && !dis_v[c];
        end
    end

    always_ff @(posedge Clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (Rst) begin
                chans[c] <= '0;
            end else if (load_v[c]) begin
                chans[c].active  <= 1'b1;
                chans[c].med_id  <= cfg_id_q;
                chans[c].period  <= period_ld;
                chans[c].count   <= period_ld;
                chans[c].pending <= 1'b0;
            end else if (dis_v[c]) begin
                chans[c].active  <= 1'b0;
                chans[c].count   <= '0;
                chans[c].pending <= 1'b0;
            end else begin
                if (Tick && chans[c].active)
                    chans[c].count <= expire_v[c] ? chans[c].period : chans[c].count - CNT_W'(1);
                if (expire_v[c])  chans[c].pending <= 1'b1;
                else if (ack_v[c]) chans[c].pending <= 1'b0;
            end
        end
    end

    // Descending scan so the first pending channel after last_served wins.
    always_comb begin
        pick_any = 1'b0;
        pick_ch  = '0;
        idx      = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(last_served) + 1 + k) % N_CH);
            if (req[idx]) begin
                pick_any = 1'b1;
                pick_ch  = idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Alarm_Valid <= 1'b0;
            Alarm_Ch    <= '0;
            Alarm_MedID <= '0;
            last_served <= CH_W'(N_CH - 1);
        end else if (Alarm_Valid) begin
            if (Alarm_Ack) begin
                Alarm_Valid <= 1'b0;
                last_served <= Alarm_Ch;
            end else if (load_v[Alarm_Ch] || dis_v[Alarm_Ch]) begin
                Alarm_Valid <= 1'b0;
            end
        end else if (pick_any) begin
            Alarm_Valid <= 1'b1;
            Alarm_Ch    <= pick_ch;
            Alarm_MedID <= chans[pick_ch].med_id;
        end
    end

    assign LED_Out = Alarm_Valid ? LED_ALARM : LED_OFF;

    always_ff @(posedge Clk) begin
        if (Rst) Disp_Rem <= '1;
        else     Disp_Rem <= chans[Disp_Ch].active ? chans[Disp_Ch].count : '1;
    end

`ifdef MSCH_MISSED_CNT_EN
    logic [MISS_W-1:0] miss [N_CH];

    // A dose is missed when a new expiry lands on a still-unacknowledged one.
    always_ff @(posedge Clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (Rst || load_v[c] || dis_v[c])
                miss[c] <= '0;
            else if (expire_v[c] && chans[c].pending && !ack_v[c] && miss[c] != '1)
                miss[c] <= miss[c] + MISS_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) Miss_Cnt <= '0;
        else     Miss_Cnt <= miss[Disp_Ch];
    end
`else
    assign Miss_Cnt = '0;
`endif

endmodule

// File: tb/tb_med_sched_multi_ch.sv
// Directed bench for med_sched_multi_ch: alarm presentations go through an expectation
// queue checked by an independent monitor; config/display results are checked inline.
module tb_med_sched_multi_ch;
    localparam int N_CH   = 4;
    localparam int ID_W   = 4;
    localparam int FREQ_W = 5;
    localparam int CNT_W  = 5;
    localparam int MISS_W = 3;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Cfg_Valid = 1'b0;
    logic              Cfg_Ready;
    logic [1:0]        Cfg_Ch = '0;
    logic [ID_W-1:0]   Cfg_MedID = '0;
    logic [FREQ_W-1:0] Cfg_Freq = '0;
    logic              Tick = 1'b0;
    logic              Alarm_Valid;
    logic [1:0]        Alarm_Ch;
    logic [ID_W-1:0]   Alarm_MedID;
    logic              Alarm_Ack = 1'b0;
    logic [3:0]        LED_Out;
    logic [1:0]        Disp_Ch = '0;
    logic [CNT_W-1:0]  Disp_Rem;
    logic [MISS_W-1:0] Miss_Cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ch_q[$];
    int exp_id_q[$];

    med_sched_multi_ch #(
        .N_CH(N_CH), .ID_W(ID_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W), .DAY_UNITS(24), .MISS_W(MISS_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready), .Cfg_Ch(Cfg_Ch),
        .Cfg_MedID(Cfg_MedID), .Cfg_Freq(Cfg_Freq), .Tick(Tick),
        .Alarm_Valid(Alarm_Valid), .Alarm_Ch(Alarm_Ch), .Alarm_MedID(Alarm_MedID),
        .Alarm_Ack(Alarm_Ack), .LED_Out(LED_Out), .Disp_Ch(Disp_Ch),
        .Disp_Rem(Disp_Rem), .Miss_Cnt(Miss_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_alarm(input int ch, input int id);
        exp_ch_q.push_back(ch);
        exp_id_q.push_back(id);
    endtask

    task automatic cfg(input int ch, input int id, input int freq, input bit tick_load,
                       output int low_cycles);
        int guard;
        @(negedge Clk);
        guard = 0;
        while (!Cfg_Ready && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        if (!Cfg_Ready) check("cfg_ready_timeout", 0, 1);
        Cfg_Valid = 1'b1;
        Cfg_Ch    = ch[1:0];
        Cfg_MedID = id[ID_W-1:0];
        Cfg_Freq  = freq[FREQ_W-1:0];
        @(negedge Clk);
        Cfg_Valid = 1'b0;
        low_cycles = 0;
        while (!Cfg_Ready && low_cycles < 50) begin
            low_cycles++;
            if (tick_load && low_cycles == CNT_W + 1) Tick = 1'b1;
            @(negedge Clk);
            Tick = 1'b0;
        end
    endtask

    task automatic tick_once();
        @(negedge Clk);
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic ack_once();
        @(negedge Clk);
        Alarm_Ack = 1'b1;
        @(negedge Clk);
        Alarm_Ack = 1'b0;
    endtask

    task automatic disp_check(input string name, input int ch, input int exp);
        Disp_Ch = ch[1:0];
        @(negedge Clk);
        check(name, int'(Disp_Rem), exp);
    endtask

    // Monitor: every new presentation must match the next queued expectation.
    initial begin
        bit prev_valid;
        bit have_exp;
        int e_ch;
        int e_id;
        prev_valid = 1'b0;
        have_exp   = 1'b0;
        e_ch = 0;
        e_id = 0;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (Alarm_Valid && !prev_valid) begin
                    if (exp_ch_q.size() == 0) begin
                        check("alarm_unexpected_ch", int'(Alarm_Ch), -1);
                        have_exp = 1'b0;
                    end else begin
                        e_ch = exp_ch_q.pop_front();
                        e_id = exp_id_q.pop_front();
                        have_exp = 1'b1;
                        check("alarm_ch", int'(Alarm_Ch), e_ch);
                        check("alarm_med_id", int'(Alarm_MedID), e_id);
                        check("led_on", int'(LED_Out), 15);
                    end
                end else if (Alarm_Valid && have_exp) begin
                    check("alarm_hold_ch", int'(Alarm_Ch), e_ch);
                end else if (!Alarm_Valid && prev_valid) begin
                    check("led_off", int'(LED_Out), 0);
                end
            end
            prev_valid = Alarm_Valid && !Rst;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;

        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        check("rst_cfg_ready", int'(Cfg_Ready), 1);
        check("rst_alarm_valid", int'(Alarm_Valid), 0);
        check("rst_alarm_ch", int'(Alarm_Ch), 0);
        check("rst_alarm_med_id", int'(Alarm_MedID), 0);
        check("rst_led", int'(LED_Out), 0);
        check("rst_disp_rem", int'(Disp_Rem), 31);
        check("rst_miss_cnt", int'(Miss_Cnt), 0);

        // ch0 id5 freq4 -> period 6
        cfg(0, 5, 4, 1'b0, low);
        check("cfg0_busy_cycles", low, CNT_W + 1);
        @(negedge Clk);
        check("ch0_disp_after_cfg", int'(Disp_Rem), 6);

        expect_alarm(0, 5);
        for (int i = 0; i < 6; i++) tick_once();
        @(negedge Clk);
        check("ch0_alarm_after_6_ticks", int'(Alarm_Valid), 1);
        check("ch0_disp_reloaded", int'(Disp_Rem), 6);
        ack_once();
        check("ch0_ack_drops_valid", int'(Alarm_Valid), 0);
        check("ch0_ack_led_off", int'(LED_Out), 0);

        // ch1/ch2 period 1, simultaneous expiry -> round robin ch1 then ch2
        cfg(1, 7, 24, 1'b0, low);
        check("cfg1_busy_cycles", low, CNT_W + 1);
        cfg(2, 9, 24, 1'b0, low);
        check("cfg2_busy_cycles", low, CNT_W + 1);
        disp_check("ch1_period_1", 1, 1);
        expect_alarm(1, 7);
        expect_alarm(2, 9);
        tick_once();
        @(negedge Clk);
        check("rr_first_valid", int'(Alarm_Valid), 1);
        ack_once();
        @(negedge Clk);
        check("rr_second_valid", int'(Alarm_Valid), 1);
        ack_once();
        repeat (2) @(negedge Clk);
        check("rr_idle_after_acks", int'(Alarm_Valid), 0);

        // disable presented ch1: drop without ack, ch2 presented next
        expect_alarm(1, 7);
        tick_once();
        @(negedge Clk);
        expect_alarm(2, 9);
        cfg(1, 0, 0, 1'b0, low);
        check("disable_no_div", low, 0);
        check("disable_drops_valid", int'(Alarm_Valid), 0);
        disp_check("ch1_disabled_disp", 1, 31);
        ack_once();
        cfg(1, 7, 30, 1'b0, low);
        check("cfg_freq30_busy", low, CNT_W + 1);
        @(negedge Clk);
        check("freq30_period_1", int'(Disp_Rem), 1);

        // Tick lands in LOAD of ch3: ch3 loads 3, ch0 decrements, ch1/ch2 expire
        expect_alarm(1, 7);
        expect_alarm(2, 9);
        cfg(3, 11, 8, 1'b1, low);
        check("cfg3_busy_cycles", low, CNT_W + 1);
        disp_check("ch3_load_wins", 3, 3);
        disp_check("ch0_decremented", 0, 3);
        disp_check("ch2_reloaded", 2, 1);
        ack_once();
        @(negedge Clk);
        ack_once();

        // missed-dose counting on ch0 with period 1
        cfg(1, 0, 0, 1'b0, low);
        cfg(2, 0, 0, 1'b0, low);
        cfg(3, 0, 0, 1'b0, low);
        cfg(0, 5, 24, 1'b0, low);
        check("cfg0_p1_busy", low, CNT_W + 1);
        Disp_Ch = 2'd0;
        expect_alarm(0, 5);
        for (int i = 0; i < 3; i++) tick_once();
        @(negedge Clk);
        check("ch0_p1_disp", int'(Disp_Rem), 1);
`ifdef MSCH_MISSED_CNT_EN
        check("miss_after_3_ticks", int'(Miss_Cnt), 2);
`else
        check("miss_tied_zero", int'(Miss_Cnt), 0);
`endif
        expect_alarm(0, 5);
        @(negedge Clk);
        Alarm_Ack = 1'b1;
        Tick = 1'b1;
        @(negedge Clk);
        Alarm_Ack = 1'b0;
        Tick = 1'b0;
        check("ack_expiry_drop", int'(Alarm_Valid), 0);
        @(negedge Clk);
        check("ack_expiry_pending_kept", int'(Alarm_Valid), 1);
`ifdef MSCH_MISSED_CNT_EN
        check("miss_no_inc_on_ack", int'(Miss_Cnt), 2);
`else
        check("miss_still_zero", int'(Miss_Cnt), 0);
`endif
        ack_once();
        repeat (2) @(negedge Clk);
        check("idle_after_final_ack", int'(Alarm_Valid), 0);
        ack_once();
        @(negedge Clk);
        check("ack_while_idle_ignored", int'(Alarm_Valid), 0);

        // reset in the middle of a divide
        @(negedge Clk);
        Cfg_Valid = 1'b1;
        Cfg_Ch    = 2'd2;
        Cfg_MedID = 4'd3;
        Cfg_Freq  = 5'd4;
        @(negedge Clk);
        Cfg_Valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        check("midrst_cfg_ready", int'(Cfg_Ready), 1);
        check("midrst_disp_rem", int'(Disp_Rem), 31);
        check("midrst_alarm_valid", int'(Alarm_Valid), 0);
        check("midrst_miss_cnt", int'(Miss_Cnt), 0);
        cfg(0, 5, 4, 1'b0, low);
        check("post_rst_cfg_busy", low, CNT_W + 1);
        @(negedge Clk);
        check("post_rst_ch0_period", int'(Disp_Rem), 6);
        disp_check("post_rst_ch2_inactive", 2, 31);

        repeat (3) @(negedge Clk);
        check("alarm_queue_drained", exp_ch_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
